// File: rtl/sram_arbiter.sv
// Two-port (fetch / data) arbiter and bus sequencer for the shared base SRAM.
// Optional feature macro: SRAM_ARB_RR_EN selects round-robin instead of data-port-first priority.
module sram_arbiter #(
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [3:0]  mem_sel,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_ack,
   output logic        stallreq,
   inout  wire  [31:0] base_ram_data,
   output logic [19:0] base_ram_addr,
   output logic [3:0]  base_ram_be_n,
   output logic        base_ram_ce_n,
   output logic        base_ram_oe_n,
   output logic        base_ram_we_n
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        port_q, port_d;      // 1 = data port granted, 0 = fetch port
   logic [19:0] addr_q, addr_d;
   logic [3:0]  be_n_q, be_n_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] mem_rdata_q, mem_rdata_d;
   logic        ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
   logic        drive_q, drive_d;
   logic        if_ack_q, if_ack_d, mem_ack_q, mem_ack_d;
   logic        grant_mem;
   logic        last_phase;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^{if_addr[31:22], if_addr[1:0], mem_addr[31:22], mem_addr[1:0]};

`ifdef SRAM_ARB_RR_EN
   logic last_mem_q, last_mem_d;
   assign grant_mem = mem_req & (~if_req | ~last_mem_q);
`else
   assign grant_mem = mem_req;
`endif

   assign last_phase = (cnt_q == 3'(WAIT_CYCLES));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      port_d      = port_q;
      addr_d      = addr_q;
      be_n_d      = be_n_q;
      wdata_d     = wdata_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
`ifdef SRAM_ARB_RR_EN
      last_mem_d  = last_mem_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (if_req || mem_req) begin
               port_d = grant_mem;
               cnt_d  = 3'd0;
`ifdef SRAM_ARB_RR_EN
               last_mem_d = grant_mem;
`endif
               if (grant_mem) begin
                  addr_d  = mem_addr[21:2];
                  wdata_d = mem_wdata;
                  be_n_d  = mem_we ? ~mem_sel : 4'b0000;
                  state_d = mem_we ? S_WR_SETUP : S_RD;
               end else begin
                  addr_d  = if_addr[21:2];
                  be_n_d  = 4'b0000;
                  state_d = S_RD;
               end
            end
         end
         S_RD: begin
            if (last_phase) begin
               state_d = S_DONE;
               if (port_q) mem_rdata_d = base_ram_data;
               else        if_rdata_d  = base_ram_data;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_WR_SETUP: begin
            cnt_d   = 3'd0;
            state_d = S_WR_PULSE;
         end
         S_WR_PULSE: begin
            if (last_phase) state_d = S_WR_HOLD;
            else            cnt_d   = cnt_q + 3'd1;
         end
         S_WR_HOLD: state_d = S_DONE;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Strobes and acks are decoded from the next state so the pins come straight from flops.
   always_comb begin
      ce_n_d    = !(state_d == S_RD || state_d == S_WR_SETUP ||
                    state_d == S_WR_PULSE || state_d == S_WR_HOLD);
      oe_n_d    = (state_d != S_RD);
      we_n_d    = (state_d != S_WR_PULSE);
      drive_d   = (state_d == S_WR_SETUP || state_d == S_WR_PULSE || state_d == S_WR_HOLD);
      if_ack_d  = (state_d == S_DONE) && !port_d;
      mem_ack_d = (state_d == S_DONE) && port_d;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 3'd0;
         port_q      <= 1'b0;
         addr_q      <= 20'd0;
         be_n_q      <= 4'b1111;
         wdata_q     <= 32'd0;
         if_rdata_q  <= 32'd0;
         mem_rdata_q <= 32'd0;
         ce_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         drive_q     <= 1'b0;
         if_ack_q    <= 1'b0;
         mem_ack_q   <= 1'b0;
`ifdef SRAM_ARB_RR_EN
         last_mem_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         port_q      <= port_d;
         addr_q      <= addr_d;
         be_n_q      <= be_n_d;
         wdata_q     <= wdata_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
         ce_n_q      <= ce_n_d;
         oe_n_q      <= oe_n_d;
         we_n_q      <= we_n_d;
         drive_q     <= drive_d;
         if_ack_q    <= if_ack_d;
         mem_ack_q   <= mem_ack_d;
`ifdef SRAM_ARB_RR_EN
         last_mem_q  <= last_mem_d;
`endif
      end
   end

   assign base_ram_data = drive_q ? wdata_q : 32'bz;
   assign base_ram_addr = addr_q;
   assign base_ram_be_n = be_n_q;
   assign base_ram_ce_n = ce_n_q;
   assign base_ram_oe_n = oe_n_q;
   assign base_ram_we_n = we_n_q;
   assign if_rdata      = if_rdata_q;
   assign mem_rdata     = mem_rdata_q;
   assign if_ack        = if_ack_q;
   assign mem_ack       = mem_ack_q;
   assign stallreq      = (if_req & ~if_ack_q) | (mem_req & ~mem_ack_q);

endmodule
